lift_call_queue: RTL and testbench

- Request-scheduling stage directly upstream of the lift car controller.
- Latches hall-call and cab-button presses into a pending-floor bitmap.
- Picks the next target floor with a direction-preserving (SCAN) policy and hands it to the controller over a valid/ready handshake.
- Clears each request when the controller reports arrival at that floor, and sends the idle car back to the home floor after a timeout.

---
 rtl/lift_call_queue.sv | 157 +++++++++++++++
 tb/tb_lift_call_queue.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lift_call_queue.sv
// Latches hall/cab presses into a pending bitmap and offers the next SCAN-order target floor to the car controller.
// Press-to-offer takes 2 cycles; the offered target_floor holds still until the controller raises target_ready.
module lift_call_queue #(
    parameter int FLOORS       = 8,
    parameter int FLOOR_W      = 3,
    parameter int HOME_FLOOR   = 3,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FLOORS-1:0]  hall_req,
    input  logic [FLOORS-1:0]  cab_req,
    input  logic [FLOOR_W-1:0] cur_floor,
    input  logic               arrive,
    output logic [FLOOR_W-1:0] target_floor,
    output logic               target_valid,
    input  logic               target_ready,
    output logic               dir_up,
    output logic [FLOORS-1:0]  pending,
    output logic               busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_TRAVEL = 2'd2;

    localparam int               CNT_W    = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(IDLE_TIMEOUT - 1);
    localparam logic [FLOOR_W-1:0] HOME   = FLOOR_W'(HOME_FLOOR);

    logic [1:0]         state;
    logic [CNT_W-1:0]   idle_cnt;
    logic [FLOORS-1:0]  req;
    logic [FLOORS-1:0]  req_q;
    logic [FLOORS-1:0]  req_edge;
    logic [FLOORS-1:0]  clr_mask;
    logic               armed;
    logic               cur_ok;

    logic [FLOOR_W-1:0] up_floor;
    logic [FLOOR_W-1:0] dn_floor;
    logic               found_up;
    logic               found_dn;
    logic [FLOOR_W-1:0] sel_floor;
    logic               sel_flip;

    assign req    = hall_req | cab_req;
    // armed stays low for the first clock after reset so buttons held through reset need a fresh press
    assign req_edge = armed ? (req & ~req_q) : '0;
    assign cur_ok = (int'(cur_floor) < FLOORS);

    always_comb begin
        clr_mask = '0;
        if (arrive && cur_ok) begin
            clr_mask[cur_floor] = 1'b1;
        end
    end

    always_comb begin
        found_up = 1'b0;
        found_dn = 1'b0;
        up_floor = '0;
        dn_floor = '0;
        for (int i = FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (i > int'(cur_floor))) begin
                found_up = 1'b1;
                up_floor = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < FLOORS; i++) begin
            if (pending[i] && (i < int'(cur_floor))) begin
                found_dn = 1'b1;
                dn_floor = FLOOR_W'(i);
            end
        end
    end

    always_comb begin
        sel_floor = cur_floor;
        sel_flip  = 1'b0;
        if (cur_ok && pending[cur_floor]) begin
            sel_floor = cur_floor;
        end else if (dir_up) begin
            if (found_up) begin
                sel_floor = up_floor;
            end else begin
                sel_floor = dn_floor;
                sel_flip  = found_dn;
            end
        end else begin
            if (found_dn) begin
                sel_floor = dn_floor;
            end else begin
                sel_floor = up_floor;
                sel_flip  = found_up;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            req_q   <= '0;
            armed   <= 1'b0;
        end else begin
            req_q   <= req;
            armed   <= 1'b1;
            // clear beats a same-cycle press at the arrival floor
            pending <= (pending | req_edge) & ~clr_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            target_floor <= HOME;
            dir_up       <= 1'b1;
            idle_cnt     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|pending) begin
                        target_floor <= sel_floor;
                        if (sel_flip) begin
                            dir_up <= ~dir_up;
                        end
                        idle_cnt <= '0;
                        state    <= S_ISSUE;
                    end else if (idle_cnt == CNT_MAX) begin
                        if (cur_floor != HOME) begin
                            target_floor <= HOME;
                            idle_cnt     <= '0;
                            state        <= S_ISSUE;
                        end
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (target_ready) begin
                        state <= S_TRAVEL;
                    end
                end
                S_TRAVEL: begin
                    if (arrive) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign target_valid = (state == S_ISSUE);
    assign busy         = (state != S_IDLE);

endmodule

// File: tb/tb_lift_call_queue.sv
// Directed scenarios plus random traffic, every cycle compared against a queue-based scheduling model.
module tb_lift_call_queue;

    localparam int HOME = 3;
    localparam int TMO  = 16;

    logic       clk;
    logic       rst_n;
    logic [7:0] hall_req;
    logic [7:0] cab_req;
    logic [2:0] cur_floor;
    logic       arrive;
    logic [2:0] target_floor;
    logic       target_valid;
    logic       target_ready;
    logic       dir_up;
    logic [7:0] pending;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    // model: mode 0 = waiting, 1 = offering, 2 = car moving
    logic [7:0] m_pend;
    logic [7:0] m_prev;
    bit         m_armed;
    int         m_mode;
    logic [2:0] m_tgt;
    bit         m_up;
    int         m_cnt;

    lift_call_queue #(
        .FLOORS(8), .FLOOR_W(3), .HOME_FLOOR(HOME), .IDLE_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hall_req(hall_req), .cab_req(cab_req),
        .cur_floor(cur_floor), .arrive(arrive), .target_floor(target_floor),
        .target_valid(target_valid), .target_ready(target_ready),
        .dir_up(dir_up), .pending(pending), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_prev = '0; m_armed = 0; m_mode = 0;
        m_tgt = 3'(HOME); m_up = 1; m_cnt = 0;
    endtask

    function automatic void pick(input logic [7:0] pend, input int cur, input bit up,
                                 output int tgt, output bit flip);
        int above[$];
        int below[$];
        for (int f = 0; f < 8; f++) begin
            if (pend[f] && f > cur) above.push_back(f);
            if (pend[f] && f < cur) below.push_back(f);
        end
        flip = 0;
        tgt  = cur;
        if (pend[cur]) tgt = cur;
        else if (up) begin
            if (above.size() > 0) tgt = above[0];
            else begin tgt = below[below.size()-1]; flip = 1; end
        end else begin
            if (below.size() > 0) tgt = below[below.size()-1];
            else begin tgt = above[0]; flip = 1; end
        end
    endfunction

    task automatic model_step();
        logic [7:0] req;
        logic [7:0] rise;
        logic [7:0] clr;
        int t;
        bit fl;
        req  = hall_req | cab_req;
        rise = m_armed ? (req & ~m_prev) : 8'h00;
        clr  = arrive ? (8'h01 << cur_floor) : 8'h00;
        case (m_mode)
            0: begin
                if (m_pend != 0) begin
                    pick(m_pend, int'(cur_floor), m_up, t, fl);
                    m_tgt = 3'(t);
                    if (fl) m_up = !m_up;
                    m_cnt = 0;
                    m_mode = 1;
                end else if (m_cnt == TMO - 1) begin
                    if (int'(cur_floor) != HOME) begin
                        m_tgt = 3'(HOME); m_cnt = 0; m_mode = 1;
                    end
                end else m_cnt++;
            end
            1: if (target_ready) m_mode = 2;
            default: if (arrive) m_mode = 0;
        endcase
        m_pend  = (m_pend | rise) & ~clr;
        m_prev  = req;
        m_armed = 1;
    endtask

    task automatic compare_all();
        chk("pending", 32'(pending), 32'(m_pend));
        chk("target_valid", 32'(target_valid), 32'(m_mode == 1));
        chk("target_floor", 32'(target_floor), 32'(m_tgt));
        chk("dir_up", 32'(dir_up), 32'(m_up));
        chk("busy", 32'(busy), 32'(m_mode != 0));
    endtask

    task automatic drive(input logic [7:0] h, input logic [7:0] c, input logic [2:0] cf,
                         input bit ar, input bit rd);
        hall_req = h; cab_req = c; cur_floor = cf; arrive = ar; target_ready = rd;
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (m_mode == 0 && m_pend == 0) done = 1;
            else drive(8'h00, 8'h00, m_tgt, m_mode == 2, 1'b1);
        end
        chk("drain_done", 32'(done), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_pending"}, 32'(pending), 32'h0);
        chk({tag, "_valid"}, 32'(target_valid), 32'h0);
        chk({tag, "_target"}, 32'(target_floor), 32'(HOME));
        chk({tag, "_dir"}, 32'(dir_up), 32'h1);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        bit seen;
        logic [7:0] h;
        logic [7:0] cb;
        logic [2:0] cf;
        bit ar;
        bit rd;
        bit quiet;

        rst_n = 1'b0;
        hall_req = '0; cab_req = '0; cur_floor = 3'd3; arrive = 0; target_ready = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // press on 5 from floor 3
        drive(8'h00, 8'h00, 3'd3, 0, 1);
        drive(8'h00, 8'h20, 3'd3, 0, 1);
        chk("s1_pend", 32'(pending), 32'h20);
        chk("s1_valid_early", 32'(target_valid), 32'h0);
        drive(8'h00, 8'h00, 3'd3, 0, 1);
        chk("s1_valid", 32'(target_valid), 32'h1);
        chk("s1_target", 32'(target_floor), 32'd5);
        drive(8'h00, 8'h00, 3'd3, 0, 1);
        drive(8'h00, 8'h00, 3'd4, 0, 1);
        drive(8'h00, 8'h00, 3'd5, 1, 1);
        chk("s1_clear", 32'(pending), 32'h0);
        chk("s1_idle", 32'(busy), 32'h0);

        // SCAN order 6, 2, 1 from floor 4 going up
        drive(8'h00, 8'h46, 3'd4, 0, 1);
        drive(8'h00, 8'h00, 3'd4, 0, 1);
        chk("s2_t6", 32'(target_floor), 32'd6);
        drive(8'h00, 8'h00, 3'd5, 0, 1);
        drive(8'h00, 8'h00, 3'd6, 1, 1);
        drive(8'h00, 8'h00, 3'd6, 0, 1);
        chk("s2_t2", 32'(target_floor), 32'd2);
        chk("s2_dir", 32'(dir_up), 32'h0);
        drive(8'h00, 8'h00, 3'd6, 0, 1);
        drive(8'h00, 8'h00, 3'd2, 1, 1);
        drive(8'h00, 8'h00, 3'd2, 0, 1);
        chk("s2_t1", 32'(target_floor), 32'd1);
        drive(8'h00, 8'h00, 3'd2, 0, 1);
        drive(8'h00, 8'h00, 3'd1, 1, 1);
        chk("s2_empty", 32'(pending), 32'h0);

        // repeated press on 4 across TRAVEL and a stalled ISSUE
        drive(8'h00, 8'h80, 3'd1, 0, 1);
        drive(8'h00, 8'h00, 3'd1, 0, 1);
        drive(8'h00, 8'h00, 3'd1, 0, 1);
        drive(8'h10, 8'h00, 3'd3, 0, 0);
        drive(8'h00, 8'h00, 3'd3, 0, 0);
        drive(8'h00, 8'h00, 3'd7, 1, 0);
        drive(8'h00, 8'h00, 3'd7, 0, 0);
        chk("s3_t4", 32'(target_floor), 32'd4);
        drive(8'h10, 8'h00, 3'd7, 0, 0);
        drive(8'h40, 8'h00, 3'd7, 0, 0);
        drive(8'h00, 8'h00, 3'd7, 0, 0);
        chk("s3_pend", 32'(pending), 32'h50);
        chk("s3_hold", 32'(target_floor), 32'd4);
        chk("s3_valid", 32'(target_valid), 32'h1);
        drive(8'h00, 8'h00, 3'd7, 0, 1);

        // arrival and press on the same floor
        drive(8'h04, 8'h00, 3'd2, 1, 0);
        chk("s4_clear_wins", 32'(pending[2]), 32'h0);
        drive(8'h00, 8'h00, 3'd2, 0, 0);
        drain();

        // idle timeout away from home, then no trip when at home
        n = 0; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            drive(8'h00, 8'h00, 3'd6, 0, 0);
            n++;
            if (target_valid) seen = 1;
        end
        chk("home_latency", 32'(n), 32'd16);
        chk("home_target", 32'(target_floor), 32'(HOME));
        drive(8'h00, 8'h00, 3'd6, 0, 1);
        drive(8'h00, 8'h00, 3'd3, 1, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            drive(8'h00, 8'h00, 3'd3, 0, 0);
            if (target_valid) seen = 1;
        end
        chk("home_stay", 32'(seen), 32'h0);

        // reset mid-TRAVEL with a button held through it
        drive(8'h81, 8'h00, 3'd3, 0, 1);
        drive(8'h01, 8'h00, 3'd3, 0, 1);
        drive(8'h01, 8'h00, 3'd3, 0, 1);
        chk("s6_pend", 32'(pending), 32'h81);
        chk("s6_busy", 32'(busy), 32'h1);
        #2 rst_n = 1'b0;
        #1 check_reset_values("midreset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) drive(8'h01, 8'h00, 3'd3, 0, 0);
        chk("s6_held_ignored", 32'(pending), 32'h0);
        drive(8'h00, 8'h00, 3'd3, 0, 0);
        drive(8'h01, 8'h00, 3'd3, 0, 0);
        chk("s6_repress", 32'(pending), 32'h01);
        drain();

        // random traffic with periodic quiet stretches
        for (int c = 0; c < 2400; c++) begin
            quiet = (c % 300) >= 240;
            h = 8'h00; cb = 8'h00;
            if (!quiet && $urandom_range(0, 5) == 0) h = 8'(1 << $urandom_range(0, 7));
            if (!quiet && $urandom_range(0, 7) == 0) cb = 8'(1 << $urandom_range(0, 7));
            if (!quiet && $urandom_range(0, 9) == 0) h = h | hall_req;
            cf = cur_floor;
            if ($urandom_range(0, 9) == 0) cf = 3'($urandom_range(0, 7));
            ar = 0;
            if (m_mode == 2 && $urandom_range(0, 3) == 0) begin
                cf = m_tgt;
                ar = 1;
            end else if ($urandom_range(0, 19) == 0) ar = 1;
            rd = 1'($urandom_range(0, 1));
            drive(h, cb, cf, ar, rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
